snake_body: RTL and testbench
=============================

# snake_body

Snake body register file and movement engine for the snake game. It consumes debounced one-cycle button pulses and a game-tick enable, and maintains the ordered list of body cells (head first). It produces the packed `locations_flat`, `length` and game-status flags that feed the game core and the VGA snake controller. All movement, growth, wall and self-collision decisions are made here, one step per tick.

## Interface
Parameters:
- `MAX_LEN`, 15: maximum snake length; storage is 16 slots of 8 bits.
- `INIT_LEN`, 3: length loaded on `init`.

Ports:
- `board_clk` input 1: system clock. Reset is `reset`, asynchronous, active-high; clock is `board_clk`.
- `reset` input 1: asynchronous, active-high.
- `tick` input 1: one-cycle game-step enable, synchronous to `board_clk`.
- `init` input 1: one-cycle pulse that loads the starting snake and enters RUN.
- `btn_up`, `btn_down`, `btn_left`, `btn_right` input 1 each: debounced single-cycle pulses.
- `food` input 8: food cell as {x[3:0], y[3:0]}.
- `locations_flat` output 128: slot i at bits [8i+7:8i], packed as {x, y}; slot 0 is the head.
- `length` output 4: number of valid slots.
- `dir` output 2: current direction, where 00 = right, 01 = left, 10 = up, 11 = down.
- `ate` output 1: one-cycle pulse on a growth step.
- `dead` output 1: high while in DEAD.
- `win` output 1: high while in WIN.
- `running` output 1: high while in RUN.

## Operation
- States: IDLE, RUN, DEAD, WIN.
  - `reset` forces IDLE from any state.
  - `init` forces RUN from any state and has priority over `tick` in the same cycle.
  - RUN goes to DEAD on a wall hit or self hit.
  - RUN goes to WIN when `length` reaches `MAX_LEN`.
  - DEAD and WIN are left only by `init` or `reset`.
- Reset values:
  - `locations_flat` = 0, `length` = 0, `dir` = 00.
  - `ate` = `dead` = `win` = `running` = 0.
  - The pending-direction register is cleared.
- Init loads:
  - slot0 = (7,7), slot1 = (6,7), slot2 = (5,7); all other slots = 8'h00.
  - `length` = `INIT_LEN`, `dir` = right, pending cleared.
- Direction input:
  - A button pulse in RUN latches a pending direction.
  - When several buttons pulse in one cycle, priority is up > down > left > right.
  - A later pulse before the next tick overwrites the pending value.
  - A pending direction that is the reverse of the current `dir` is discarded when the tick is applied.
  - Pulses outside RUN are ignored.
- Step (`tick` in RUN):
  - The accepted pending direction, if any, becomes `dir`; pending is then cleared.
  - The new head is computed from slot0. Screen y grows downward, so up means y-1.
  - Wall hit: moving left at x=0, right at x=15, up at y=0, or down at y=15. Coordinates never wrap.
  - grow = (new head == `food`).
  - Self hit: new head equals slot i for i < length-1 when not growing, or for i < length when growing.
  - On a wall or self hit:
    - No shift occurs; the body and `length` are frozen.
    - The new state is DEAD.
    - `ate` is not asserted.
  - Otherwise:
    - Slots shift by one (slot i+1 ← slot i) and slot0 ← new head.
    - If grow: `length`+1 and `ate` pulses. If the new length equals `MAX_LEN`, the state becomes WIN.
    - If not growing: slot[length] is cleared to 8'h00 and `length` is unchanged.
- Slots at index ≥ `length` always read 8'h00.
- `tick` outside RUN has no effect.

## Timing
- Single clock domain with no internal clock division; `tick` arrives already divided.
- A tick sampled high at rising edge N updates `locations_flat`, `length`, `dir`, the status flags and `ate` at the same edge N. Results are visible in cycle N+1. `ate` is high for exactly that one cycle.
- A button pulse at edge N is applied by a tick at edge N+1 or later. A pulse coincident with a tick at edge N does not affect that step and stays pending for the next one.
- `init` at edge N gives the loaded state in cycle N+1.
- Reset asserted mid-step wins immediately, asynchronously. After deassertion, the first edge with `init` starts a game.

## Test plan
1. Reset then `init` → `length`=3; `locations_flat`[23:0] = {8'h57, 8'h67, 8'h77} (slot2, slot1, slot0); `dir`=00; `running`=1.
2. `food`=8'hFF and 3 ticks → head 8'hA7, slots 8'hA7/8'h97/8'h87, slot3 = 8'h00, `length` stays 3.
3. Reversal: pulse `btn_left`, then tick → head 8'h87, `dir`=00. Pulse `btn_up` and `btn_right` in the same cycle, then tick → `dir`=10, head 8'h76.
4. Growth: `food`=8'h87, one tick → `length`=4, head 8'h87, tail 8'h57 retained, `ate` high for one cycle.
5. Wall: from init, `btn_up` then 8 ticks → after tick 7 the head is 8'h70; tick 8 gives `dead`=1, body unchanged, and further ticks have no effect.
6. Self hit and reset: grow to length 5, then steer a U-turn (up, left, down) so the head lands on slot3 → `dead`=1. Assert `reset` mid-RUN → every output returns to its reset value in the same cycle.

Source files
------------

// File: rtl/snake_body_if.sv
// Bundle of control inputs and game-state outputs between the game core and snake_body.
// master drives tick/init/buttons/food; slave (the body engine) drives the snake state.
// No handshake: inputs are single-cycle pulses; outputs are registered state.
interface snake_body_if;
   logic         tick;
   logic         init;
   logic         btn_up;
   logic         btn_down;
   logic         btn_left;
   logic         btn_right;
   logic [7:0]   food;
   logic [127:0] locations_flat;
   logic [3:0]   length;
   logic [1:0]   dir;
   logic         ate;
   logic         dead;
   logic         win;
   logic         running;

   modport master (
      output tick, init, btn_up, btn_down, btn_left, btn_right, food,
      input  locations_flat, length, dir, ate, dead, win, running
   );

   modport slave (
      input  tick, init, btn_up, btn_down, btn_left, btn_right, food,
      output locations_flat, length, dir, ate, dead, win, running
   );
endinterface

// File: rtl/snake_body.sv
// Snake body register file and movement engine: one move/grow/collide step per tick.
// Latency: tick or init at edge N is visible in cycle N+1; ate pulses for that one cycle.
// Backpressure: none; button pulses latch a pending direction until the next tick.
module snake_body #(
   parameter int MAX_LEN  = 15,
   parameter int INIT_LEN = 3
) (
   input  logic          board_clk,
   input  logic          reset,
   snake_body_if.slave   bus
);
   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DEAD, S_WIN} state_t;

   localparam logic [4:0] MAX_LEN_W  = 5'(MAX_LEN);
   localparam logic [3:0] INIT_LEN_W = 4'(INIT_LEN);

   state_t      state_q, state_d;
   logic [7:0]  slot_q [16];
   logic [7:0]  slot_d [16];
   logic [3:0]  len_q, len_d;
   logic [1:0]  dir_q, dir_d;
   logic [1:0]  pend_q, pend_d;
   logic        pend_vld_q, pend_vld_d;
   logic        ate_q, ate_d;

   logic        btn_any;
   logic [1:0]  btn_dir;
   logic [1:0]  eff_dir;
   logic [3:0]  hx, hy;
   logic [7:0]  new_head;
   logic        wall_hit;
   logic        grow;
   logic        self_hit;
   logic [4:0]  hit_limit;
   logic [127:0] flat;

   // Button priority encode and the direction actually used by the next step
   always_comb begin
      btn_any = bus.btn_up | bus.btn_down | bus.btn_left | bus.btn_right;
      btn_dir = 2'b00;
      if (bus.btn_up)         btn_dir = 2'b10;
      else if (bus.btn_down)  btn_dir = 2'b11;
      else if (bus.btn_left)  btn_dir = 2'b01;
      else                    btn_dir = 2'b00;
      // Reverse pairs share bit 1 and differ in bit 0; such a request is dropped
      eff_dir = dir_q;
      if (pend_vld_q && !((pend_q[1] == dir_q[1]) && (pend_q[0] != dir_q[0])))
         eff_dir = pend_q;
   end

   // Candidate head, wall check, growth and self-collision for the coming step
   always_comb begin
      hx       = slot_q[0][7:4];
      hy       = slot_q[0][3:0];
      wall_hit = 1'b0;
      new_head = slot_q[0];
      case (eff_dir)
         2'b00: begin wall_hit = (hx == 4'd15); new_head = {hx + 4'd1, hy}; end
         2'b01: begin wall_hit = (hx == 4'd0);  new_head = {hx - 4'd1, hy}; end
         2'b10: begin wall_hit = (hy == 4'd0);  new_head = {hx, hy - 4'd1}; end
         default: begin wall_hit = (hy == 4'd15); new_head = {hx, hy + 4'd1}; end
      endcase
      grow = (new_head == bus.food);
      // The tail cell vacates during a non-growing step, so it is not an obstacle
      hit_limit = grow ? {1'b0, len_q} : ({1'b0, len_q} - 5'd1);
      self_hit  = 1'b0;
      for (int i = 0; i < 16; i++) begin
         if ((5'(i) < hit_limit) && (slot_q[i] == new_head))
            self_hit = 1'b1;
      end
   end

   // Next-state: init load, step on tick, pending-direction capture
   always_comb begin
      state_d    = state_q;
      slot_d     = slot_q;
      len_d      = len_q;
      dir_d      = dir_q;
      pend_d     = pend_q;
      pend_vld_d = pend_vld_q;
      ate_d      = 1'b0;
      if (bus.init) begin
         state_d = S_RUN;
         for (int i = 0; i < 16; i++) slot_d[i] = 8'h00;
         slot_d[0]  = 8'h77;
         slot_d[1]  = 8'h67;
         slot_d[2]  = 8'h57;
         len_d      = INIT_LEN_W;
         dir_d      = 2'b00;
         pend_d     = 2'b00;
         pend_vld_d = 1'b0;
      end else if (state_q == S_RUN) begin
         if (bus.tick) begin
            dir_d      = eff_dir;
            // A pulse coincident with the tick is kept for the following step
            pend_vld_d = btn_any;
            pend_d     = btn_any ? btn_dir : 2'b00;
            if (wall_hit || self_hit) begin
               state_d = S_DEAD;
            end else begin
               for (int i = 1; i < 16; i++) slot_d[i] = slot_q[i-1];
               slot_d[0] = new_head;
               if (grow) begin
                  len_d = len_q + 4'd1;
                  ate_d = 1'b1;
                  if (({1'b0, len_q} + 5'd1) == MAX_LEN_W) state_d = S_WIN;
               end else begin
                  slot_d[len_q] = 8'h00;
               end
            end
         end else if (btn_any) begin
            pend_vld_d = 1'b1;
            pend_d     = btn_dir;
         end
      end
   end

   // State registers with asynchronous active-high reset
   always_ff @(posedge board_clk or posedge reset) begin
      if (reset) begin
         state_q    <= S_IDLE;
         for (int i = 0; i < 16; i++) slot_q[i] <= 8'h00;
         len_q      <= 4'd0;
         dir_q      <= 2'b00;
         pend_q     <= 2'b00;
         pend_vld_q <= 1'b0;
         ate_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         slot_q     <= slot_d;
         len_q      <= len_d;
         dir_q      <= dir_d;
         pend_q     <= pend_d;
         pend_vld_q <= pend_vld_d;
         ate_q      <= ate_d;
      end
   end

   // Pack the slots, head in the low byte
   always_comb begin
      flat = '0;
      for (int i = 0; i < 16; i++) flat[8*i +: 8] = slot_q[i];
   end

   assign bus.locations_flat = flat;
   assign bus.length         = len_q;
   assign bus.dir            = dir_q;
   assign bus.ate            = ate_q;
   assign bus.dead           = (state_q == S_DEAD);
   assign bus.win            = (state_q == S_WIN);
   assign bus.running        = (state_q == S_RUN);
endmodule

// File: tb/tb_snake_body.sv
// Directed bench for snake_body: reset, init, movement, reversal, growth, wall and self hit.
// Inputs driven on the falling edge; outputs sampled 1 time unit after the rising edge.
// Each scenario task does its own inline comparisons.
module tb_snake_body;
   logic board_clk = 1'b0;
   logic reset     = 1'b1;
   int   tests     = 0;
   int   fails     = 0;

   snake_body_if sif ();

   snake_body #(.MAX_LEN(15), .INIT_LEN(3)) dut (
      .board_clk (board_clk),
      .reset     (reset),
      .bus       (sif)
   );

   always #5 board_clk = ~board_clk;

   // One clock cycle of stimulus; btn = {up, down, left, right}
   task automatic cyc(input logic t, input logic i, input logic [3:0] btn);
      @(negedge board_clk);
      sif.tick      = t;
      sif.init      = i;
      sif.btn_up    = btn[3];
      sif.btn_down  = btn[2];
      sif.btn_left  = btn[1];
      sif.btn_right = btn[0];
      @(posedge board_clk);
      #1;
      sif.tick = 1'b0; sif.init = 1'b0;
      sif.btn_up = 1'b0; sif.btn_down = 1'b0; sif.btn_left = 1'b0; sif.btn_right = 1'b0;
   endtask

   task automatic test_reset;
      sif.tick = 0; sif.init = 0; sif.food = 8'hFF;
      sif.btn_up = 0; sif.btn_down = 0; sif.btn_left = 0; sif.btn_right = 0;
      reset = 1'b1;
      repeat (2) @(posedge board_clk);
      #1;
      tests++;
      if ({sif.locations_flat, sif.length, sif.dir, sif.ate, sif.dead, sif.win, sif.running} !== 140'd0) begin
         fails++;
         $display("FAIL reset_outputs got flat=%h len=%0d dir=%b ate=%b dead=%b win=%b run=%b want all zero",
                  sif.locations_flat, sif.length, sif.dir, sif.ate, sif.dead, sif.win, sif.running);
      end
      @(negedge board_clk);
      reset = 1'b0;
      cyc(1'b1, 1'b0, 4'b1000);
      tests++;
      if (sif.length !== 4'd0 || sif.running !== 1'b0 || sif.locations_flat !== 128'd0) begin
         fails++;
         $display("FAIL idle_tick got len=%0d run=%b flat=%h want 0 0 0", sif.length, sif.running, sif.locations_flat);
      end
   endtask

   task automatic test_init;
      cyc(1'b0, 1'b1, 4'b0000);
      tests++;
      if (sif.length !== 4'd3 || sif.locations_flat[23:0] !== 24'h576777 || sif.dir !== 2'b00 || sif.running !== 1'b1) begin
         fails++;
         $display("FAIL init got len=%0d slots=%h dir=%b run=%b want 3 576777 00 1",
                  sif.length, sif.locations_flat[23:0], sif.dir, sif.running);
      end
      tests++;
      if (sif.locations_flat[127:24] !== 104'd0) begin
         fails++;
         $display("FAIL init_upper got %h want 0", sif.locations_flat[127:24]);
      end
   endtask

   task automatic test_move;
      sif.food = 8'hFF;
      cyc(1'b0, 1'b1, 4'b0000);
      repeat (3) cyc(1'b1, 1'b0, 4'b0000);
      tests++;
      if (sif.locations_flat[31:0] !== 32'h008797A7 || sif.length !== 4'd3) begin
         fails++;
         $display("FAIL move3 got slots=%h len=%0d want 008797a7 3", sif.locations_flat[31:0], sif.length);
      end
   endtask

   task automatic test_reversal;
      sif.food = 8'hFF;
      cyc(1'b0, 1'b1, 4'b0000);
      cyc(1'b0, 1'b0, 4'b0010);
      cyc(1'b1, 1'b0, 4'b0000);
      tests++;
      if (sif.locations_flat[7:0] !== 8'h87 || sif.dir !== 2'b00) begin
         fails++;
         $display("FAIL reverse_drop got head=%h dir=%b want 87 00", sif.locations_flat[7:0], sif.dir);
      end
      cyc(1'b0, 1'b1, 4'b0000);
      cyc(1'b0, 1'b0, 4'b1001);
      cyc(1'b1, 1'b0, 4'b0000);
      tests++;
      if (sif.locations_flat[7:0] !== 8'h76 || sif.dir !== 2'b10) begin
         fails++;
         $display("FAIL btn_priority got head=%h dir=%b want 76 10", sif.locations_flat[7:0], sif.dir);
      end
   endtask

   task automatic test_back_to_back;
      sif.food = 8'hFF;
      cyc(1'b0, 1'b1, 4'b0000);
      cyc(1'b1, 1'b0, 4'b1000);
      tests++;
      if (sif.locations_flat[7:0] !== 8'h87 || sif.dir !== 2'b00) begin
         fails++;
         $display("FAIL coincident_pulse got head=%h dir=%b want 87 00", sif.locations_flat[7:0], sif.dir);
      end
      cyc(1'b1, 1'b0, 4'b0000);
      tests++;
      if (sif.locations_flat[7:0] !== 8'h86 || sif.dir !== 2'b10) begin
         fails++;
         $display("FAIL pending_kept got head=%h dir=%b want 86 10", sif.locations_flat[7:0], sif.dir);
      end
   endtask

   task automatic test_growth;
      sif.food = 8'h87;
      cyc(1'b0, 1'b1, 4'b0000);
      cyc(1'b1, 1'b0, 4'b0000);
      tests++;
      if (sif.length !== 4'd4 || sif.locations_flat[31:0] !== 32'h57677787 || sif.ate !== 1'b1) begin
         fails++;
         $display("FAIL grow got len=%0d slots=%h ate=%b want 4 57677787 1",
                  sif.length, sif.locations_flat[31:0], sif.ate);
      end
      sif.food = 8'hFF;
      cyc(1'b0, 1'b0, 4'b0000);
      tests++;
      if (sif.ate !== 1'b0) begin
         fails++;
         $display("FAIL ate_pulse got ate=%b want 0", sif.ate);
      end
   endtask

   task automatic test_wall;
      sif.food = 8'hFF;
      cyc(1'b0, 1'b1, 4'b0000);
      cyc(1'b0, 1'b0, 4'b1000);
      repeat (7) cyc(1'b1, 1'b0, 4'b0000);
      tests++;
      if (sif.locations_flat[7:0] !== 8'h70 || sif.dead !== 1'b0) begin
         fails++;
         $display("FAIL wall_edge got head=%h dead=%b want 70 0", sif.locations_flat[7:0], sif.dead);
      end
      cyc(1'b1, 1'b0, 4'b0000);
      tests++;
      if (sif.dead !== 1'b1 || sif.running !== 1'b0 || sif.locations_flat[23:0] !== 24'h727170 ||
          sif.length !== 4'd3 || sif.ate !== 1'b0) begin
         fails++;
         $display("FAIL wall_hit got dead=%b run=%b slots=%h len=%0d ate=%b want 1 0 727170 3 0",
                  sif.dead, sif.running, sif.locations_flat[23:0], sif.length, sif.ate);
      end
      cyc(1'b1, 1'b0, 4'b0100);
      tests++;
      if (sif.dead !== 1'b1 || sif.locations_flat[23:0] !== 24'h727170) begin
         fails++;
         $display("FAIL dead_frozen got dead=%b slots=%h want 1 727170", sif.dead, sif.locations_flat[23:0]);
      end
   endtask

   task automatic test_self_hit;
      cyc(1'b0, 1'b1, 4'b0000);
      sif.food = 8'h87;
      cyc(1'b1, 1'b0, 4'b0000);
      sif.food = 8'h97;
      cyc(1'b1, 1'b0, 4'b0000);
      sif.food = 8'hFF;
      tests++;
      if (sif.length !== 4'd5 || sif.locations_flat[39:0] !== 40'h5767778797) begin
         fails++;
         $display("FAIL grow5 got len=%0d slots=%h want 5 5767778797", sif.length, sif.locations_flat[39:0]);
      end
      cyc(1'b0, 1'b0, 4'b1000);
      cyc(1'b1, 1'b0, 4'b0000);
      cyc(1'b0, 1'b0, 4'b0010);
      cyc(1'b1, 1'b0, 4'b0000);
      cyc(1'b0, 1'b0, 4'b0100);
      cyc(1'b1, 1'b0, 4'b0000);
      tests++;
      if (sif.dead !== 1'b1 || sif.length !== 4'd5 || sif.locations_flat[39:0] !== 40'h7787979686) begin
         fails++;
         $display("FAIL self_hit got dead=%b len=%0d slots=%h want 1 5 7787979686",
                  sif.dead, sif.length, sif.locations_flat[39:0]);
      end
   endtask

   task automatic test_reset_mid;
      sif.food = 8'hFF;
      cyc(1'b0, 1'b1, 4'b0000);
      cyc(1'b1, 1'b0, 4'b0000);
      cyc(1'b0, 1'b0, 4'b1000);
      @(negedge board_clk);
      reset = 1'b1;
      #1;
      tests++;
      if ({sif.locations_flat, sif.length, sif.dir, sif.ate, sif.dead, sif.win, sif.running} !== 140'd0) begin
         fails++;
         $display("FAIL async_reset got flat=%h len=%0d dir=%b run=%b want all zero",
                  sif.locations_flat, sif.length, sif.dir, sif.running);
      end
      @(negedge board_clk);
      reset = 1'b0;
      cyc(1'b0, 1'b1, 4'b0000);
      cyc(1'b1, 1'b0, 4'b0000);
      tests++;
      if (sif.locations_flat[23:0] !== 24'h677787 || sif.dir !== 2'b00 || sif.running !== 1'b1) begin
         fails++;
         $display("FAIL restart got slots=%h dir=%b run=%b want 677787 00 1",
                  sif.locations_flat[23:0], sif.dir, sif.running);
      end
   endtask

   initial begin
      test_reset();
      test_init();
      test_move();
      test_reversal();
      test_back_to_back();
      test_growth();
      test_wall();
      test_self_hit();
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
